// File: rtl/l2_maintenance_sequencer.sv
// L2 maintenance sequencer: walks every (set, way) pair of the cache, or of an inclusive set
// range when L2_MAINT_RANGE_EN is defined, and issues one flush/invalidate request per pair.
module l2_maintenance_sequencer #(
  parameter int NUM_SETS        = 256,
  parameter int NUM_WAYS        = 8,
  parameter int MAX_OUTSTANDING = 4,
  localparam int SET_BITS       = $clog2(NUM_SETS),
  localparam int WAY_BITS       = $clog2(NUM_WAYS)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [1:0]          cmd_op,
`ifdef L2_MAINT_RANGE_EN
  input  logic [SET_BITS-1:0] cmd_first_set,
  input  logic [SET_BITS-1:0] cmd_last_set,
`endif
  output logic                mreq_valid,
  output logic [1:0]          mreq_op,
  output logic [SET_BITS-1:0] mreq_set,
  output logic [WAY_BITS-1:0] mreq_way,
  input  logic                mreq_ready,
  input  logic                mreq_ack,
  output logic                busy,
  output logic                done,
  output logic                ack_err
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  localparam logic [1:0]          OP_RESERVED = 2'd3;
  localparam logic [3:0]          MAX_CNT     = 4'(MAX_OUTSTANDING);
  localparam logic [WAY_BITS-1:0] LAST_WAY    = WAY_BITS'(NUM_WAYS - 1);
  localparam logic [SET_BITS-1:0] TOP_SET     = SET_BITS'(NUM_SETS - 1);

  logic [1:0]          state, state_n;
  logic [3:0]          out_cnt, cnt_n;
  logic [1:0]          op_q;
  logic [SET_BITS-1:0] set_q;
  logic [WAY_BITS-1:0] way_q;
  logic [SET_BITS-1:0] first_set_in;
  logic [SET_BITS-1:0] last_set;
  logic                empty_cmd;

`ifdef L2_MAINT_RANGE_EN
  logic [SET_BITS-1:0] last_set_q;

  assign first_set_in = cmd_first_set;
  assign last_set     = last_set_q;
  assign empty_cmd    = (cmd_op == OP_RESERVED) || (cmd_first_set > cmd_last_set);
`else
  assign first_set_in = '0;
  assign last_set     = TOP_SET;
  assign empty_cmd    = (cmd_op == OP_RESERVED);
`endif

  logic accept, xfer, ack_ok, ack_bad, last_pair;

  assign accept    = (state == ST_IDLE) && cmd_valid;
  assign xfer      = mreq_valid && mreq_ready;
  assign ack_ok    = mreq_ack && (out_cnt != 4'd0);
  assign ack_bad   = mreq_ack && (out_cnt == 4'd0);
  assign last_pair = (set_q == last_set) && (way_q == LAST_WAY);

  assign mreq_op  = op_q;
  assign mreq_set = set_q;
  assign mreq_way = way_q;

  // NOTE: every variable driven here gets a default first, so no path can infer a latch.
  always_comb begin
    cnt_n = out_cnt;
    if (xfer && !ack_ok)
      cnt_n = out_cnt + 4'd1;
    else if (!xfer && ack_ok)
      cnt_n = out_cnt - 4'd1;

    state_n = state;
    case (state)
      ST_IDLE:  if (cmd_valid) state_n = empty_cmd ? ST_DONE : ST_ISSUE;
      ST_ISSUE: if (xfer && last_pair) state_n = ST_DRAIN;
      // Using the next count lets done follow the final ack by exactly one cycle.
      ST_DRAIN: if (cnt_n == 4'd0) state_n = ST_DONE;
      default:  state_n = ST_IDLE;
    endcase
  end

  // Outputs are registered from next-state values, so they decode the state they belong to.
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= ST_IDLE;
      out_cnt    <= 4'd0;
      op_q       <= 2'd0;
      set_q      <= '0;
      way_q      <= '0;
`ifdef L2_MAINT_RANGE_EN
      last_set_q <= '0;
`endif
      cmd_ready  <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
      mreq_valid <= 1'b0;
      ack_err    <= 1'b0;
    end else begin
      state      <= state_n;
      out_cnt    <= cnt_n;
      cmd_ready  <= (state_n == ST_IDLE);
      busy       <= (state_n != ST_IDLE);
      done       <= (state_n == ST_DONE);
      mreq_valid <= (state_n == ST_ISSUE) && (cnt_n < MAX_CNT);

      if (accept) begin
        op_q       <= cmd_op;
        set_q      <= first_set_in;
        way_q      <= '0;
`ifdef L2_MAINT_RANGE_EN
        last_set_q <= cmd_last_set;
`endif
      end else if (xfer && !last_pair) begin
        if (way_q == LAST_WAY) begin
          way_q <= '0;
          set_q <= set_q + SET_BITS'(1);
        end else begin
          way_q <= way_q + WAY_BITS'(1);
        end
      end

      // A spurious ack in the acceptance cycle still reports, so set wins over clear.
      if (ack_bad)
        ack_err <= 1'b1;
      else if (accept)
        ack_err <= 1'b0;
    end
  end

endmodule
